// File: rtl/alu_uart_host.sv
// alu_uart_host: sends operand A, operand B and the opcode as three UART bytes,
// then waits for the one-byte ALU result (or gives up after TIMEOUT cycles).
module alu_uart_host #(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned NB_CODE    = 6,
  parameter int unsigned NB_STATE   = 4,
  parameter int unsigned NB_TIMEOUT = 20,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_CODE-1:0] i_op,
  input  logic               i_tx_done,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx,
  output logic               o_busy,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_timeout
);

  localparam logic [NB_STATE-1:0] IDLE     = NB_STATE'(0);
  localparam logic [NB_STATE-1:0] SEND_A   = NB_STATE'(1);
  localparam logic [NB_STATE-1:0] WAIT_A   = NB_STATE'(2);
  localparam logic [NB_STATE-1:0] SEND_B   = NB_STATE'(3);
  localparam logic [NB_STATE-1:0] WAIT_B   = NB_STATE'(4);
  localparam logic [NB_STATE-1:0] SEND_OP  = NB_STATE'(5);
  localparam logic [NB_STATE-1:0] WAIT_OP  = NB_STATE'(6);
  localparam logic [NB_STATE-1:0] WAIT_RES = NB_STATE'(7);

  localparam logic [NB_TIMEOUT-1:0] TERM_CNT = NB_TIMEOUT'(TIMEOUT - 1);

  logic [NB_STATE-1:0]   state_q, state_d;
  logic [NB_DATA-1:0]    a_q, a_d, b_q, b_d, op_q, op_d;
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
  logic                  tx_start_q, tx_start_d;
  logic [NB_DATA-1:0]    tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [NB_DATA-1:0]    result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  timeout_q, timeout_d;

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_q       <= '0;
      busy_q     <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next state; outputs are computed one cycle ahead so they come straight from flops
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_d       = tx_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d        = i_data_a;
          b_d        = i_data_b;
          op_d       = NB_DATA'(i_op);
          tx_start_d = 1'b1;
          tx_d       = i_data_a;
          state_d    = SEND_A;
        end
      end
      SEND_A:  state_d = WAIT_A;
      WAIT_A: begin
        if (i_tx_done) begin
          tx_start_d = 1'b1;
          tx_d       = b_q;
          state_d    = SEND_B;
        end
      end
      SEND_B:  state_d = WAIT_B;
      WAIT_B: begin
        if (i_tx_done) begin
          tx_start_d = 1'b1;
          tx_d       = op_q;
          state_d    = SEND_OP;
        end
      end
      SEND_OP: state_d = WAIT_OP;
      WAIT_OP: begin
        if (i_tx_done) begin
          cnt_d   = '0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A result arriving on the terminal count beats the timeout
        if (i_rx_done) begin
          result_d = i_rx;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == TERM_CNT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + NB_TIMEOUT'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign o_tx_start     = tx_start_q;
  assign o_tx           = tx_q;
  assign o_busy         = busy_q;
  assign o_result       = result_q;
  assign o_result_valid = valid_q;
  assign o_timeout      = timeout_q;

endmodule

// File: doc/alu_uart_host.md
Name: alu_uart_host

Overview:
- Host-side counterpart of the UART ALU interface.
- Takes a parallel operation (operand A, operand B, opcode) and serialises it as three bytes A, B, OP through a UART transmitter byte port.
- Then waits for the single result byte on the UART receiver byte port and presents it with a valid pulse.
- Used as the command master in FPGA-to-FPGA links and as the stimulus engine in system-level benches of the ALU-over-UART design.

Parameters:
- NB_DATA, 8, UART byte width; also operand and result width.
- NB_CODE, 6, opcode width; sent zero-extended to NB_DATA.
- NB_STATE, 4, state register width.
- NB_TIMEOUT, 20, width of the response timeout counter.
- TIMEOUT, 1000000, max cycles spent in WAIT_RES before abort (must be ≥2 and < 2^NB_TIMEOUT).

Ports:
- i_clk, input, 1, system clock; all logic on rising edge.
- i_reset, input, 1, synchronous, active-high reset.
- i_start, input, 1, request pulse; sampled only in IDLE.
- i_data_a, input, NB_DATA, operand A; latched on accepted start.
- i_data_b, input, NB_DATA, operand B; latched on accepted start.
- i_op, input, NB_CODE, opcode; latched on accepted start.
- i_tx_done, input, 1, UART transmitter finished current byte (1-cycle pulse).
- i_rx_done, input, 1, UART receiver has a new byte on i_rx (1-cycle pulse).
- i_rx, input, NB_DATA, received byte; valid when i_rx_done=1.
- o_tx_start, output, 1, 1-cycle request to UART transmitter.
- o_tx, output, NB_DATA, byte to transmit; stable while o_tx_start=1 and until next send.
- o_busy, output, 1, high in every state except IDLE.
- o_result, output, NB_DATA, last received ALU result; holds until next successful result.
- o_result_valid, output, 1, 1-cycle pulse when o_result updated.
- o_timeout, output, 1, 1-cycle pulse when response wait aborted.

Behaviour:
- Reset (synchronous, i_reset=1 at clock edge):
  - state=IDLE.
  - o_tx_start=0, o_tx=0, o_busy=0, o_result=0, o_result_valid=0, o_timeout=0.
  - Latched operands and timeout counter cleared.
  - Applies mid-operation: any in-flight sequence is abandoned; no pulse emitted.
- States: IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES.
- IDLE:
  - i_start=1 → latch i_data_a, i_data_b, {zeros, i_op}; go to SEND_A.
  - i_start outside IDLE is ignored, not queued.
- SEND_x (one cycle each):
  - o_tx_start=1, o_tx=corresponding byte.
  - Unconditionally advances to WAIT_x.
- WAIT_x:
  - o_tx_start=0.
  - Stays until i_tx_done=1, then WAIT_A→SEND_B, WAIT_B→SEND_OP, WAIT_OP→WAIT_RES.
  - i_tx_done in any other state is ignored.
- Timing:
  - o_tx_start for A is high in the cycle after the start is accepted.
  - Each subsequent o_tx_start is high in the cycle after the i_tx_done that ended the previous byte.
- WAIT_RES:
  - Timeout counter cleared on entry; increments each cycle in WAIT_RES.
  - i_rx_done=1 → o_result←i_rx, o_result_valid=1 next cycle, go to IDLE.
  - If the counter reaches TIMEOUT-1 with i_rx_done=0 → o_timeout=1 next cycle, go to IDLE, o_result unchanged.
  - i_rx_done and the timeout terminal count in the same cycle → result wins; no timeout pulse.
- i_rx_done outside WAIT_RES (e.g. echo bytes during send phases) is ignored; o_result is not modified.
- o_result_valid and o_timeout are mutually exclusive and never high for more than one cycle.
- o_busy falls in the same cycle the result/timeout pulse is high.
- A new i_start may be accepted in that same cycle.
- Byte order on the wire is fixed: A, B, OP. The opcode byte has upper NB_DATA-NB_CODE bits zero.

Test Plan:
- Reset, then i_start with A=8'h05, B=8'h03, op=6'b100000 → o_tx_start pulses carry 8'h05, 8'h03, 8'h20 in order, each one cycle after the previous i_tx_done. Inject i_rx=8'h08 with i_rx_done → o_result=8'h08, o_result_valid high exactly one cycle, o_busy low.
- Back-to-back: i_start held high continuously with A=8'hFF, B=8'h01, op=6'b100010 → second sequence begins only after the first result pulse. No extra o_tx_start while busy; second frame bytes are 8'hFF, 8'h01, 8'h22.
- Timeout with TIMEOUT=16: complete all three sends, never assert i_rx_done → o_timeout pulses exactly 16 cycles after entering WAIT_RES. o_result keeps its previous value (8'h08); state returns to IDLE.
- Spurious strobes: assert i_rx_done with i_rx=8'hAA during WAIT_A and i_tx_done during IDLE → no state change, o_result unchanged, no pulses.
- Race with TIMEOUT=16: assert i_rx_done with i_rx=8'h5A in the terminal count cycle → o_result=8'h5A, o_result_valid=1, o_timeout stays 0.
- Reset in WAIT_B (after A sent) → next cycle all outputs at reset values. Following i_start with A=8'h11 starts cleanly from SEND_A with o_tx=8'h11.
